// File: rtl/dcache_pkg.sv
// Shared parameters, state encoding and address-field helpers for the
// direct-mapped write-back data cache.
package dcache_pkg;

  localparam int ADDR_W   = 8;
  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 2;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES    = 1 << INDEX_W;
  localparam int BLOCK_W  = 8 << OFFSET_W;
  localparam int BLKA_W   = ADDR_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_e;

  typedef logic [TAG_W-1:0]    tag_t;
  typedef logic [INDEX_W-1:0]  index_t;
  typedef logic [OFFSET_W-1:0] offset_t;

  function automatic tag_t addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic index_t addr_index(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic offset_t addr_offset(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W-1:0];
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Line storage: valid/dirty (reset), tag and data (not reset), with a byte
// write port, a whole-line fill port and combinational read-out.
module dcache_line_array
  import dcache_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  index_t             index_i,
  input  offset_t            offset_i,
  output logic               valid_o,
  output logic               dirty_o,
  output tag_t               tag_o,
  output logic [BLOCK_W-1:0] data_o,
  input  logic               byte_we_i,
  input  logic [7:0]         byte_data_i,
  input  logic               fill_we_i,
  input  tag_t               fill_tag_i,
  input  logic [BLOCK_W-1:0] fill_data_i
);

  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;
  tag_t               tag_q  [LINES];
  logic [BLOCK_W-1:0] data_q [LINES];

  // Valid/dirty bookkeeping: a fill yields a clean line, a store marks it dirty
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we_i) begin
      valid_q[index_i] <= 1'b1;
      dirty_q[index_i] <= 1'b0;
    end else if (byte_we_i) begin
      dirty_q[index_i] <= 1'b1;
    end
  end

  // Tag and data payload
  always_ff @(posedge clk_i) begin
    if (fill_we_i) begin
      tag_q[index_i]  <= fill_tag_i;
      data_q[index_i] <= fill_data_i;
    end else if (byte_we_i) begin
      data_q[index_i][{offset_i, 3'b000} +: 8] <= byte_data_i;
    end
  end

  assign valid_o = valid_q[index_i];
  assign dirty_o = dirty_q[index_i];
  assign tag_o   = tag_q[index_i];
  assign data_o  = data_q[index_i];

endmodule

// File: rtl/dcache_dm_wb.sv
// Direct-mapped, write-back, write-allocate byte cache: hits complete with no
// stall; misses write back a dirty victim, fetch the block, then retry as a hit.
module dcache_dm_wb
  import dcache_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic               READ,
  input  logic               WRITE,
  input  logic [ADDR_W-1:0]  ADDRESS,
  input  logic [7:0]         WRITEDATA,
  output logic [7:0]         READDATA,
  output logic               BUSYWAIT,
  output logic               mem_read,
  output logic               mem_write,
  output logic [BLKA_W-1:0]  mem_address,
  output logic [BLOCK_W-1:0] mem_writedata,
  input  logic [BLOCK_W-1:0] mem_readdata,
  input  logic               mem_busywait
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   miss_addr_q, miss_addr_d;
  logic [ADDR_W-1:0]   arr_addr_s;
  logic                cpu_req_s;
  logic                hit_s;
  logic                byte_we_s;
  logic                fill_we_s;
  logic                line_valid_s;
  logic                line_dirty_s;
  tag_t                line_tag_s;
  logic [BLOCK_W-1:0]  line_data_s;

  // Outside IDLE the array follows the latched miss address, so the memory
  // transaction stays stable even if the CPU drops or changes its request.
  assign arr_addr_s = (state_q == IDLE) ? ADDRESS : miss_addr_q;
  assign cpu_req_s  = READ | WRITE;
  assign hit_s      = line_valid_s && (line_tag_s == addr_tag(arr_addr_s));
  assign byte_we_s  = WRITE && hit_s && (state_q == IDLE) && !RESET;
  assign fill_we_s  = (state_q == FETCH) && !mem_busywait && !RESET;

  dcache_line_array u_lines (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .index_i     (addr_index(arr_addr_s)),
    .offset_i    (addr_offset(arr_addr_s)),
    .valid_o     (line_valid_s),
    .dirty_o     (line_dirty_s),
    .tag_o       (line_tag_s),
    .data_o      (line_data_s),
    .byte_we_i   (byte_we_s),
    .byte_data_i (WRITEDATA),
    .fill_we_i   (fill_we_s),
    .fill_tag_i  (addr_tag(arr_addr_s)),
    .fill_data_i (mem_readdata)
  );

  // State and miss-address registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    if (state_q == IDLE) begin
      miss_addr_d = ADDRESS;
    end else begin
      miss_addr_d = miss_addr_q;
    end
    case (state_q)
      IDLE: begin
        if (cpu_req_s && !hit_s) begin
          state_d = line_dirty_s ? WRITEBACK : FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      WRITEBACK: begin
        if (!mem_busywait) begin
          state_d = FETCH;
        end else begin
          state_d = WRITEBACK;
        end
      end
      FETCH: begin
        if (!mem_busywait) begin
          state_d = UPDATE;
        end else begin
          state_d = FETCH;
        end
      end
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory strobes and CPU-side outputs
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    case (state_q)
      WRITEBACK: begin
        mem_write     = 1'b1;
        mem_address   = {line_tag_s, addr_index(arr_addr_s)};
        mem_writedata = line_data_s;
      end
      FETCH: begin
        mem_read    = 1'b1;
        mem_address = miss_addr_q[ADDR_W-1:OFFSET_W];
      end
      default: begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    endcase
    BUSYWAIT = cpu_req_s && !((state_q == IDLE) && hit_s);
    if (READ && hit_s) begin
      READDATA = line_data_s[{addr_offset(arr_addr_s), 3'b000} +: 8];
    end else begin
      READDATA = 8'h00;
    end
  end

endmodule

// File: tb/tb_dcache_dm_wb.sv
// Bench for dcache_dm_wb: directed vector table, randomized traffic against a
// CPU-view memory model, and a reset-during-fetch sequence.
module tb_dcache_dm_wb;

  localparam int LAT   = 5;
  localparam int CLEAN = 2 + LAT;
  localparam int DIRTY = 2 + 2 * LAT;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  always #5 CLK = ~CLK;

  dcache_dm_wb dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  function automatic logic [7:0] pat(input logic [7:0] a);
    return a ^ 8'h5A;
  endfunction

  // Main memory: fixed LAT-cycle latency, busywait raised combinationally
  logic [31:0] bmem [64];
  int          mem_cnt;
  logic        mem_init;

  always @(posedge CLK) begin
    if (mem_init) begin
      mem_cnt <= 0;
      for (int b = 0; b < 64; b++)
        bmem[b] <= {pat(8'(4*b+3)), pat(8'(4*b+2)), pat(8'(4*b+1)), pat(8'(4*b))};
    end else if (mem_read || mem_write) begin
      if (mem_cnt == LAT-1) begin
        mem_cnt <= 0;
        if (mem_write) bmem[mem_address] <= mem_writedata;
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end else begin
      mem_cnt <= 0;
    end
  end

  assign mem_readdata = bmem[mem_address];
  assign mem_busywait = (mem_read || mem_write) && (mem_cnt != LAT-1);

  int vecs = 0;
  int errs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CPU-visible memory plus line bookkeeping; predicts data and stall length
  logic [7:0] ref_mem [256];
  logic       m_valid [8];
  logic       m_dirty [8];
  logic [2:0] m_tag   [8];

  task automatic model_reset();
    for (int x = 0; x < 8; x++) begin
      m_valid[x] = 1'b0;
      m_dirty[x] = 1'b0;
    end
  endtask

  task automatic model_op(input logic wr, input logic [7:0] a, input logic [7:0] wd,
                          output int stalls, output logic [7:0] rd);
    logic [2:0] idx;
    logic [2:0] tg;
    idx = a[4:2];
    tg  = a[7:5];
    if (m_valid[idx] && m_tag[idx] == tg) begin
      stalls = 0;
    end else begin
      stalls = m_dirty[idx] ? DIRTY : CLEAN;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = 1'b0;
    end
    if (wr) begin
      ref_mem[a]   = wd;
      m_dirty[idx] = 1'b1;
    end
    rd = ref_mem[a];
  endtask

  task automatic cpu_op(input logic wr, input logic [7:0] a, input logic [7:0] wd,
                        output int stalls, output logic [7:0] rd,
                        output logic [5:0] wb_a, output logic [31:0] wb_d,
                        output logic [5:0] rd_a, output int rd_cyc);
    logic        pr, pw;
    logic [5:0]  pa;
    logic [31:0] pd;
    stalls = 0; rd = '0; wb_a = '0; wb_d = '0; rd_a = '0; rd_cyc = 0;
    pr = 1'b0; pw = 1'b0; pa = '0; pd = '0;
    WRITE = wr; READ = !wr; ADDRESS = a; WRITEDATA = wd;
    @(negedge CLK);
    while (BUSYWAIT && stalls < 100) begin
      stalls++;
      if (mem_write) begin
        if (pw) begin
          check("wb_addr_stable", mem_address, pa);
          check("wb_data_stable", mem_writedata, pd);
        end
        wb_a = mem_address;
        wb_d = mem_writedata;
      end
      if (mem_read) begin
        if (pr) check("rd_addr_stable", mem_address, pa);
        rd_a = mem_address;
        rd_cyc++;
      end
      pr = mem_read; pw = mem_write; pa = mem_address; pd = mem_writedata;
      @(negedge CLK);
    end
    if (stalls >= 100) check("busywait_timeout", 32'd1, 32'd0);
    rd = READDATA;
    @(posedge CLK);
    #1;
    READ = 1'b0;
    WRITE = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [7:0]  a;
    logic [7:0]  wd;
    int          stall;
    logic [7:0]  rd;
    logic        chk_wb;
    logic [5:0]  wb_a;
    logic [31:0] wb_d;
  } vec_t;

  initial begin
    vec_t        tv [11];
    int          st, rc, est;
    logic [7:0]  rd, erd, a, wd;
    logic [5:0]  wa, ra;
    logic [31:0] wdat;
    logic        wr;

    tv[0]  = '{1'b0, 8'h00, 8'h00, CLEAN, 8'h5A, 1'b0, 6'h00, 32'h0};
    tv[1]  = '{1'b0, 8'h03, 8'h00, 0,     8'h59, 1'b0, 6'h00, 32'h0};
    tv[2]  = '{1'b1, 8'h01, 8'hAB, 0,     8'h00, 1'b0, 6'h00, 32'h0};
    tv[3]  = '{1'b0, 8'h01, 8'h00, 0,     8'hAB, 1'b0, 6'h00, 32'h0};
    tv[4]  = '{1'b0, 8'h20, 8'h00, DIRTY, 8'h7A, 1'b1, 6'h00, 32'h5958AB5A};
    tv[5]  = '{1'b1, 8'h45, 8'h3C, CLEAN, 8'h00, 1'b0, 6'h00, 32'h0};
    tv[6]  = '{1'b0, 8'h45, 8'h00, 0,     8'h3C, 1'b0, 6'h00, 32'h0};
    tv[7]  = '{1'b0, 8'h44, 8'h00, 0,     8'h1E, 1'b0, 6'h00, 32'h0};
    tv[8]  = '{1'b0, 8'h01, 8'h00, CLEAN, 8'hAB, 1'b0, 6'h00, 32'h0};
    tv[9]  = '{1'b0, 8'h65, 8'h00, DIRTY, 8'h3F, 1'b1, 6'h11, 32'h1D1C3C1E};
    tv[10] = '{1'b0, 8'h45, 8'h00, CLEAN, 8'h3C, 1'b0, 6'h00, 32'h0};

    READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
    RESET = 1'b1; mem_init = 1'b1;
    for (int x = 0; x < 256; x++) ref_mem[x] = pat(8'(x));
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0; mem_init = 1'b0;
    @(negedge CLK);
    check("reset_busywait", BUSYWAIT, 1'b0);
    check("reset_mem_read", mem_read, 1'b0);
    check("reset_mem_write", mem_write, 1'b0);
    check("reset_readdata", READDATA, 8'h00);
    @(posedge CLK);
    #1;

    // Directed table
    for (int i = 0; i < 11; i++) begin
      cpu_op(tv[i].wr, tv[i].a, tv[i].wd, st, rd, wa, wdat, ra, rc);
      model_op(tv[i].wr, tv[i].a, tv[i].wd, est, erd);
      check("dir_stall", st, tv[i].stall);
      if (!tv[i].wr) check("dir_rdata", rd, tv[i].rd);
      if (tv[i].stall > 0) begin
        check("dir_fetch_addr", ra, tv[i].a[7:2]);
        check("dir_fetch_cycles", rc, LAT);
      end
      if (tv[i].chk_wb) begin
        check("dir_wb_addr", wa, tv[i].wb_a);
        check("dir_wb_data", wdat, tv[i].wb_d);
      end
      if (i == 5) check("mem_untouched", bmem[6'h11][15:8], 8'h1F);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 250; n++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 95));
      wd = 8'($urandom);
      cpu_op(wr, a, wd, st, rd, wa, wdat, ra, rc);
      model_op(wr, a, wd, est, erd);
      check("rnd_stall", st, est);
      if (!wr) check("rnd_rdata", rd, erd);
    end

    // Reset during FETCH: dirty line 1 loses its store, line 0 fill is abandoned
    cpu_op(1'b1, 8'h45, 8'h77, st, rd, wa, wdat, ra, rc);
    model_op(1'b1, 8'h45, 8'h77, est, erd);
    cpu_op(1'b0, 8'h80, 8'h00, st, rd, wa, wdat, ra, rc);
    model_op(1'b0, 8'h80, 8'h00, est, erd);
    check("pre_rst_rdata", rd, erd);
    READ = 1'b1; ADDRESS = 8'hA0;
    @(negedge CLK);
    check("miss_busywait", BUSYWAIT, 1'b1);
    @(negedge CLK);
    check("fetch_mem_read", mem_read, 1'b1);
    check("fetch_mem_addr", mem_address, 6'h28);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0; READ = 1'b0;
    @(negedge CLK);
    check("rst_mid_mem_read", mem_read, 1'b0);
    check("rst_mid_mem_write", mem_write, 1'b0);
    check("rst_mid_busywait", BUSYWAIT, 1'b0);
    @(posedge CLK);
    #1;
    model_reset();
    for (int x = 0; x < 256; x++) ref_mem[x] = bmem[6'(x >> 2)][8*(x % 4) +: 8];
    cpu_op(1'b0, 8'h00, 8'h00, st, rd, wa, wdat, ra, rc);
    model_op(1'b0, 8'h00, 8'h00, est, erd);
    check("post_rst_stall0", st, CLEAN);
    check("post_rst_rdata0", rd, erd);
    cpu_op(1'b0, 8'h45, 8'h00, st, rd, wa, wdat, ra, rc);
    model_op(1'b0, 8'h45, 8'h00, est, erd);
    check("post_rst_stall45", st, CLEAN);
    check("post_rst_rdata45", rd, erd);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
